// File: rtl/adder_arb_pkg.sv
// Shared constants for the two-requester adder arbiter: state encoding,
// default widths and the round-robin pick rule.
package adder_arb_pkg;

  localparam int DEF_WIDTH = 6;
  localparam int DEF_CNT_W = 8;

  typedef logic [1:0] arb_state_t;

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] ADD  = 2'd1;
  localparam logic [1:0] RESP = 2'd2;

  // Returns the requester index to grant; a tie goes to the one not granted last.
  function automatic logic rr_pick(input logic v0, input logic v1, input logic last);
    if (v0 && v1) begin
      return !last;
    end
    return v1;
  endfunction

endpackage

// File: rtl/six_bit_adder.sv
// Ripple-carry adder: one full-adder cell per bit, carry chained LSB to MSB.
module six_bit_adder #(
  parameter int WIDTH = 6
) (
  input  logic [WIDTH-1:0] i_a,
  input  logic [WIDTH-1:0] i_b,
  input  logic             i_cin,
  output logic [WIDTH-1:0] o_sum,
  output logic             o_cout
);

  logic [WIDTH:0] w_carry;

  assign w_carry[0] = i_cin;

  generate
    for (genvar gi = 0; gi < WIDTH; gi++) begin : g_fa
      logic w_p;
      assign w_p            = i_a[gi] ^ i_b[gi];
      assign o_sum[gi]      = w_p ^ w_carry[gi];
      assign w_carry[gi+1]  = (i_a[gi] & i_b[gi]) | (w_carry[gi] & w_p);
    end
  endgenerate

  assign o_cout = w_carry[WIDTH];

endmodule

// File: rtl/adder_arbiter.sv
// Two-requester round-robin front end sharing one ripple-carry adder;
// each accepted operation yields one registered response after two cycles.
module adder_arbiter
  import adder_arb_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int CNT_W = DEF_CNT_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req0_valid,
  input  logic [WIDTH-1:0] req0_a,
  input  logic [WIDTH-1:0] req0_b,
  input  logic             req0_cin,
  output logic             req0_ready,
  input  logic             req1_valid,
  input  logic [WIDTH-1:0] req1_a,
  input  logic [WIDTH-1:0] req1_b,
  input  logic             req1_cin,
  output logic             req1_ready,
  output logic             rsp_valid,
  output logic             rsp_id,
  output logic [WIDTH-1:0] rsp_sum,
  output logic             rsp_carry,
  input  logic             rsp_ready,
  output logic [CNT_W-1:0] ops_count
);

  arb_state_t       r_state;
  logic             r_last;
  logic [WIDTH-1:0] r_a;
  logic [WIDTH-1:0] r_b;
  logic             r_cin;
  logic             r_id;
  logic [WIDTH-1:0] r_sum;
  logic             r_carry;
  logic             r_rsp_id;
  logic [CNT_W-1:0] r_ops;

  logic             w_any;
  logic             w_pick;
  logic             w_grant;
  logic [WIDTH-1:0] w_sum;
  logic             w_cout;

  assign w_any   = req0_valid | req1_valid;
  assign w_pick  = rr_pick(req0_valid, req1_valid, r_last);
  // Readies are combinational so the requester sees its accept in the grant cycle.
  assign w_grant = (r_state == IDLE) && w_any && !rst;

  assign req0_ready = w_grant && !w_pick;
  assign req1_ready = w_grant &&  w_pick;

  six_bit_adder #(
    .WIDTH (WIDTH)
  ) u_adder (
    .i_a    (r_a),
    .i_b    (r_b),
    .i_cin  (r_cin),
    .o_sum  (w_sum),
    .o_cout (w_cout)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state  <= IDLE;
      r_last   <= 1'b1;
      r_a      <= '0;
      r_b      <= '0;
      r_cin    <= 1'b0;
      r_id     <= 1'b0;
      r_sum    <= '0;
      r_carry  <= 1'b0;
      r_rsp_id <= 1'b0;
      r_ops    <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_any) begin
            r_a     <= w_pick ? req1_a   : req0_a;
            r_b     <= w_pick ? req1_b   : req0_b;
            r_cin   <= w_pick ? req1_cin : req0_cin;
            r_id    <= w_pick;
            r_last  <= w_pick;
            r_state <= ADD;
          end
        end
        ADD: begin
          r_sum    <= w_sum;
          r_carry  <= w_cout;
          r_rsp_id <= r_id;
          r_state  <= RESP;
        end
        RESP: begin
          if (rsp_ready) begin
            r_ops   <= r_ops + CNT_W'(1);
            r_state <= IDLE;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign rsp_valid = (r_state == RESP);
  assign rsp_id    = r_rsp_id;
  assign rsp_sum   = r_sum;
  assign rsp_carry = r_carry;
  assign ops_count = r_ops;

endmodule
